// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: control, config handshake and divided-clock outputs of clk_div_ctrl.
interface clk_div_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             sync_in;
  logic             tick;
  logic             clk_out;
  logic             busy;
  modport master (
    output start, stop, cfg_valid, cfg_div, sync_in,
    input  cfg_ready, tick, clk_out, busy
  );
  modport slave (
    input  start, stop, cfg_valid, cfg_div, sync_in,
    output cfg_ready, tick, clk_out, busy
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time sample-clock divider; ratio/stop changes land on period boundaries.
// Optional phase-align on sync_in when CLKDIV_SYNC_EN is defined.
module clk_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 128
) (
  input  logic         sys_clk,
  input  logic         reset,
  clk_div_ctrl_if.slave ctrl
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_div_q, pend_div_d;
  logic [CNT_W-1:0] cfg_clamped, last;
  logic [CNT_W:0]   half;
  logic             pend_q, pend_d, clk_out_q, clk_out_d;
  logic             active, period_end, sync, xfer, wrap;
  assign active      = state_q != IDLE;
  assign last        = div_q - CNT_W'(1);
  assign period_end  = active && cnt_q == last;
  assign cfg_clamped = ctrl.cfg_div < CNT_W'(2) ? CNT_W'(2) : ctrl.cfg_div;
  assign ctrl.cfg_ready = !active || !pend_q;
  assign xfer        = ctrl.cfg_valid && ctrl.cfg_ready;
`ifdef CLKDIV_SYNC_EN
  assign sync = active && ctrl.sync_in;
`else
  logic unused_sync_in;
  assign unused_sync_in = ctrl.sync_in;
  assign sync = 1'b0;
`endif
  // A sync restart is treated like a period end so a staged ratio lands there too.
  assign wrap = period_end || sync;
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    if (!active) begin
      state_d = ctrl.start ? RUN : IDLE;
      div_d   = xfer ? cfg_clamped : div_q;
    end else begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (xfer) begin
        pend_d     = 1'b1;
        pend_div_d = cfg_clamped;
      end
      if (wrap && pend_q) begin
        div_d  = pend_div_q;
        pend_d = 1'b0;
      end
      if (state_q == RUN && ctrl.stop)
        state_d = period_end ? IDLE : STOPPING;
      else if (state_q == STOPPING && ctrl.start && !ctrl.stop)
        state_d = RUN;
      else if (state_q == STOPPING && period_end)
        state_d = IDLE;
    end
    // High half starts at ceil(D/2) of the ratio that governs the next cycle.
    half      = ({1'b0, div_d} + 1'b1) >> 1;
    clk_out_d = state_d != IDLE && {1'b0, cnt_d} >= half;
  end
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= CNT_W'(DEF_DIV);
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      clk_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      clk_out_q  <= clk_out_d;
    end
  end
  assign ctrl.tick    = period_end;
  assign ctrl.clk_out = clk_out_q;
  assign ctrl.busy    = active;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed checks of clk_div_ctrl at CNT_W=8, DEF_DIV=128.
module tb_clk_div_ctrl;
  logic sys_clk, reset;
  int   passed = 0, fails = 0, total = 0;
  int   n, t;
  clk_div_ctrl_if #(.CNT_W(8)) ifc();
  clk_div_ctrl #(.CNT_W(8), .DEF_DIV(128)) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .ctrl   (ifc.slave)
  );
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) @(negedge sys_clk);
  endtask
  task automatic check_period(input string tag, input int d);
    logic [255:0] oc, ot, ec, et;
    oc = '0; ot = '0; ec = '0; et = '0;
    for (int i = 0; i < d; i++) begin
      oc[i] = ifc.clk_out;
      ot[i] = ifc.tick;
      ec[i] = i >= (d + 1) / 2;
      et[i] = i == d - 1;
      @(negedge sys_clk);
    end
    chk({tag, "_clk"}, oc, ec);
    chk({tag, "_tick"}, ot, et);
  endtask
  task automatic wait_tick(input int lim, output int c);
    c = 0;
    while (!ifc.tick && c < lim) begin
      @(negedge sys_clk);
      c++;
    end
  endtask
  task automatic wait_idle(input int lim, output int c, output int ticks);
    c = 0;
    ticks = 0;
    while (ifc.busy && c < lim) begin
      ticks += int'(ifc.tick);
      @(negedge sys_clk);
      c++;
    end
  endtask
  task automatic cfg(input logic [7:0] v);
    ifc.cfg_valid = 1'b1;
    ifc.cfg_div   = v;
    @(negedge sys_clk);
    ifc.cfg_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b0;
    ifc.start = 1'b0; ifc.stop = 1'b0; ifc.cfg_valid = 1'b0; ifc.cfg_div = '0; ifc.sync_in = 1'b0;
    cyc(3);
    chk("rst_tick", ifc.tick, 0);
    chk("rst_clk", ifc.clk_out, 0);
    chk("rst_ready", ifc.cfg_ready, 1);
    chk("rst_busy", ifc.busy, 0);
    reset = 1'b1;
    cyc(1);
    // Default ratio 128
    ifc.start = 1'b1; cyc(1); ifc.start = 1'b0;
    chk("start_busy", ifc.busy, 1);
    check_period("p128a", 128);
    check_period("p128b", 128);
    ifc.stop = 1'b1; cyc(1); ifc.stop = 1'b0;
    wait_idle(300, n, t);
    chk("stop128_lat", n, 127);
    chk("stop128_ticks", t, 1);
    // Ratio 5 written in IDLE
    chk("idle_ready", ifc.cfg_ready, 1);
    cfg(8'd5);
    ifc.start = 1'b1; cyc(1); ifc.start = 1'b0;
    check_period("p5a", 5);
    check_period("p5b", 5);
    // Stage 10 while running, then 4 at cnt=3
    chk("run_ready", ifc.cfg_ready, 1);
    cfg(8'd10);
    chk("pend_ready10", ifc.cfg_ready, 0);
    wait_tick(40, n);
    chk("finish_p5", n, 3);
    cyc(1);
    chk("ready_back10", ifc.cfg_ready, 1);
    check_period("p10", 10);
    cyc(3);
    cfg(8'd4);
    chk("pend_ready4", ifc.cfg_ready, 0);
    wait_tick(40, n);
    chk("finish_p10", n, 5);
    chk("ready_at_end", ifc.cfg_ready, 0);
    cyc(1);
    chk("ready_back4", ifc.cfg_ready, 1);
    check_period("p4", 4);
    // Stop at cnt=2 with D=8
    cfg(8'd8);
    wait_tick(40, n);
    chk("finish_p4", n, 2);
    cyc(1);
    cyc(2);
    ifc.stop = 1'b1; cyc(1); ifc.stop = 1'b0;
    chk("stopping_busy", ifc.busy, 1);
    wait_idle(40, n, t);
    chk("stop8_lat", n, 5);
    chk("stop8_ticks", t, 1);
    chk("stop8_clk", ifc.clk_out, 0);
    chk("stop8_tick", ifc.tick, 0);
    // Start during STOPPING cancels the stop without a gap
    ifc.start = 1'b1; cyc(1); ifc.start = 1'b0;
    cyc(2);
    ifc.stop = 1'b1; cyc(1); ifc.stop = 1'b0;
    ifc.start = 1'b1; cyc(1); ifc.start = 1'b0;
    wait_tick(40, n);
    chk("cancel_tick", n, 3);
    cyc(1);
    chk("cancel_busy", ifc.busy, 1);
    check_period("p8", 8);
    chk("cancel_busy2", ifc.busy, 1);
    // Ratio 1 clamps to 2
    cfg(8'd1);
    wait_tick(40, n);
    chk("finish_p8", n, 6);
    cyc(1);
    check_period("p2a", 2);
    check_period("p2b", 2);
    // Asynchronous reset mid-period with a staged ratio
    cfg(8'd6);
    chk("p2_high", ifc.clk_out, 1);
    chk("pend_ready6", ifc.cfg_ready, 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", ifc.busy, 0);
    chk("arst_clk", ifc.clk_out, 0);
    chk("arst_tick", ifc.tick, 0);
    chk("arst_ready", ifc.cfg_ready, 1);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    ifc.start = 1'b1; cyc(1); ifc.start = 1'b0;
    check_period("p128r", 128);
    // sync_in at cnt=9 with D=16
    cfg(8'd16);
    wait_tick(300, n);
    chk("finish_p128r", n, 126);
    cyc(1);
    cyc(9);
    ifc.sync_in = 1'b1; cyc(1); ifc.sync_in = 1'b0;
    wait_tick(40, n);
`ifdef CLKDIV_SYNC_EN
    chk("sync_tick", n, 15);
`else
    chk("sync_ignored", n, 5);
`endif
    cyc(1);
    check_period("p16", 16);
    // Stop at cnt=0, then simultaneous start/stop in IDLE with clamped ratio 0
    ifc.stop = 1'b1; cyc(1); ifc.stop = 1'b0;
    wait_idle(40, n, t);
    chk("stop16_lat", n, 15);
    cfg(8'd0);
    ifc.start = 1'b1; ifc.stop = 1'b1; cyc(1); ifc.start = 1'b0; ifc.stop = 1'b0;
    chk("start_wins", ifc.busy, 1);
    check_period("pclamp0", 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
